// File: rtl/jk_trace_decoder.sv
// Recovers the X/Y input stream of the two-JK-flip-flop circuit from its sampled F1/F2 trace,
// packs recovered Y bits into words and flags impossible transitions. Optional: JKDEC_IDLE_TIMEOUT_EN.
module jk_trace_decoder #(
  parameter int unsigned WORD_W   = 8,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned IDLE_LIM = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_valid,
  input  logic              f1,
  input  logic              f2,
  output logic              sync,
  output logic              sym_valid,
  output logic              x_out,
  output logic              y_out,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic              idle_to
);

  localparam int unsigned   CW   = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

  typedef enum logic {UNSYNC, TRACK} state_t;

  state_t              state, state_n;
  logic                ref_a, ref_b;
  logic [CW-1:0]       cnt;
  logic [WORD_W-2:0]   sh, sh_n;
  logic                hold, step, illegal, ybit, word_done, load, timeout;

  assign sync = (state == TRACK);

  always_comb begin
    hold      = f_valid && (state == TRACK) && (f1 == ref_a) && (f2 == ref_b);
    illegal   = f_valid && (state == TRACK) && (f1 != ref_a) && (f2 != ref_b);
    step      = f_valid && (state == TRACK) && !hold && !illegal;
    // With X=0 the circuit gives A'=Y^B, so Y is recovered as A'^B using the old B
    ybit      = f1 ^ ref_b;
    word_done = step && (cnt == LAST);
    load      = word_done && (!word_valid || word_ready);
  end

  always_comb begin
    sh_n = sh;
    for (int unsigned i = 0; i < WORD_W - 1; i++) begin
      if (cnt == CW'(i)) sh_n[i] = ybit;
    end
  end

  always_comb begin
    state_n = state;
    if (f_valid) begin
      if (state == UNSYNC) state_n = TRACK;
      else if (timeout)    state_n = UNSYNC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= UNSYNC;
      ref_a      <= 1'b0;
      ref_b      <= 1'b0;
      cnt        <= '0;
      sh         <= '0;
      sym_valid  <= 1'b0;
      x_out      <= 1'b0;
      y_out      <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state     <= state_n;
      sym_valid <= step || hold;
      x_out     <= hold;
      y_out     <= step && ybit;
      err_pulse <= illegal;
      if (f_valid) begin
        ref_a <= f1;
        ref_b <= f2;
      end
      if (illegal || timeout) begin
        cnt <= '0;
      end else if (step) begin
        cnt <= word_done ? '0 : cnt + CW'(1);
        sh  <= sh_n;
      end
      if (illegal && (err_count != '1)) err_count <= err_count + CNT_W'(1);
      // A load in the handshake cycle keeps word_valid high with the new word
      if (load) begin
        word_out   <= {ybit, sh};
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      if (word_done && !load) overflow <= 1'b1;
    end
  end

`ifdef JKDEC_IDLE_TIMEOUT_EN
  localparam int unsigned IW = $clog2(IDLE_LIM + 1);
  logic [IW-1:0] idle_cnt;

  assign timeout = hold && (idle_cnt == IW'(IDLE_LIM - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
      idle_to  <= 1'b0;
    end else begin
      idle_to <= timeout;
      if (timeout || step || illegal || (state == UNSYNC)) idle_cnt <= '0;
      else if (hold)                                        idle_cnt <= idle_cnt + IW'(1);
    end
  end
`else
  logic idle_lim_unused;
  assign idle_lim_unused = (IDLE_LIM != 0);
  assign timeout         = 1'b0;
  assign idle_to         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_trace_decoder.sv
// Directed, table-driven bench for jk_trace_decoder (WORD_W=4, CNT_W=8, IDLE_LIM=3).
module tb_jk_trace_decoder;

  logic       clk = 1'b0;
  logic       reset, f_valid, f1, f2, word_ready;
  logic       sync, sym_valid, x_out, y_out, word_valid, overflow, err_pulse, idle_to;
  logic [3:0] word_out;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  jk_trace_decoder #(.WORD_W(4), .CNT_W(8), .IDLE_LIM(3)) dut (
    .clk(clk), .reset(reset), .f_valid(f_valid), .f1(f1), .f2(f2),
    .sync(sync), .sym_valid(sym_valid), .x_out(x_out), .y_out(y_out),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .overflow(overflow), .err_pulse(err_pulse), .err_count(err_count), .idle_to(idle_to)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, fv, a, b, wr;
    logic sync, sv, x, y, ep, wv;
    logic [3:0] wo;
    logic ov;
    logic [7:0] ec;
    logic it;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, fv, a, b, wr, s, sv, x, y, ep, wv,
                              input logic [3:0] wo, input logic ov, input logic [7:0] ec,
                              input logic it);
    vec_t v;
    v.rst = rst; v.fv = fv; v.a = a; v.b = b; v.wr = wr;
    v.sync = s; v.sv = sv; v.x = x; v.y = y; v.ep = ep; v.wv = wv;
    v.wo = wo; v.ov = ov; v.ec = ec; v.it = it;
    return v;
  endfunction

  task automatic drive(input logic rst, fv, a, b, wr);
    @(negedge clk);
    reset = rst; f_valid = fv; f1 = a; f2 = b; word_ready = wr;
  endtask

  task automatic run(input vec_t v, input string name);
    logic [18:0] act, exp;
    drive(v.rst, v.fv, v.a, v.b, v.wr);
    @(posedge clk);
    #1;
    act = {sync, sym_valid, x_out, y_out, err_pulse, word_valid, word_out, overflow, err_count, idle_to};
    exp = {v.sync, v.sv, v.x, v.y, v.ep, v.wv, v.wo, v.ov, v.ec, v.it};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got sync,sv,x,y,ep,wv,wo,ov,ec,it=%b required %b", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; f_valid = 1'b0; f1 = 1'b0; f2 = 1'b0; word_ready = 1'b1;

    // rst fv a b wr | sync sv x y ep wv wo ov ec it
    vecs.push_back(mk(1,0,0,0,1, 0,0,0,0,0,0,4'b0000,0,8'd0,0));
    // word of Y=1,0,1,1 delivered immediately
    vecs.push_back(mk(0,1,0,0,1, 1,0,0,0,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,1,0,1, 1,1,0,1,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,0,0,1, 1,1,0,0,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,1,0,1, 1,1,0,1,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,1,1,1, 1,1,0,1,0,1,4'b1101,0,8'd0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,0,0,0,0,0,4'b1101,0,8'd0,0));
    // hold then two steps
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,0,1,0, 1,0,0,0,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,0,1,0, 1,1,1,0,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,1,1,0, 1,1,0,0,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,0,1,0, 1,1,0,1,0,0,4'b0000,0,8'd0,0));
    // illegal 10->01, then legal step from reference 01
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,0,0,0, 1,0,0,0,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,1,0,0, 1,1,0,1,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,0,1,0, 1,0,0,0,1,0,4'b0000,0,8'd1,0));
    vecs.push_back(mk(0,1,0,0,0, 1,1,0,1,0,0,4'b0000,0,8'd1,0));
    // backpressure: first word held, second dropped
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,0,0,0, 1,0,0,0,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,1,0,0, 1,1,0,1,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,0,0,0, 1,1,0,0,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,1,0,0, 1,1,0,1,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,0,0,0, 1,1,0,0,0,1,4'b0101,0,8'd0,0));
    vecs.push_back(mk(0,1,1,0,0, 1,1,0,1,0,1,4'b0101,0,8'd0,0));
    vecs.push_back(mk(0,1,0,0,0, 1,1,0,0,0,1,4'b0101,0,8'd0,0));
    vecs.push_back(mk(0,1,1,0,0, 1,1,0,1,0,1,4'b0101,0,8'd0,0));
    vecs.push_back(mk(0,1,0,0,0, 1,1,0,0,0,1,4'b0101,1,8'd0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,0,0,0,0,0,4'b0101,1,8'd0,0));
    // word completes in the same cycle as a handshake
    vecs.push_back(mk(0,1,1,0,0, 1,1,0,1,0,0,4'b0101,1,8'd0,0));
    vecs.push_back(mk(0,1,0,0,0, 1,1,0,0,0,0,4'b0101,1,8'd0,0));
    vecs.push_back(mk(0,1,1,0,0, 1,1,0,1,0,0,4'b0101,1,8'd0,0));
    vecs.push_back(mk(0,1,0,0,0, 1,1,0,0,0,1,4'b0101,1,8'd0,0));
    vecs.push_back(mk(0,1,1,0,0, 1,1,0,1,0,1,4'b0101,1,8'd0,0));
    vecs.push_back(mk(0,1,1,1,0, 1,1,0,1,0,1,4'b0101,1,8'd0,0));
    vecs.push_back(mk(0,1,0,1,0, 1,1,0,1,0,1,4'b0101,1,8'd0,0));
    vecs.push_back(mk(0,1,0,0,1, 1,1,0,1,0,1,4'b1111,1,8'd0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,0,0,0,0,0,4'b1111,1,8'd0,0));
    // reset mid-word, reseed, fresh word 1,1,0,0
    vecs.push_back(mk(0,1,1,0,1, 1,1,0,1,0,0,4'b1111,1,8'd0,0));
    vecs.push_back(mk(0,1,0,0,1, 1,1,0,0,0,0,4'b1111,1,8'd0,0));
    vecs.push_back(mk(0,1,1,0,1, 1,1,0,1,0,0,4'b1111,1,8'd0,0));
    vecs.push_back(mk(1,0,0,0,1, 0,0,0,0,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,1,1,1, 1,0,0,0,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,0,1,1, 1,1,0,1,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,0,0,1, 1,1,0,1,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,0,1,1, 1,1,0,0,0,0,4'b0000,0,8'd0,0));
    vecs.push_back(mk(0,1,1,1,1, 1,1,0,0,0,1,4'b0011,0,8'd0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,0,0,0,0,0,4'b0011,0,8'd0,0));

    for (int i = 0; i < vecs.size(); i++) run(vecs[i], $sformatf("vec%0d", i));

    // run of holds: timeout with the feature, steady tracking without it
    run(mk(1,0,0,0,1, 0,0,0,0,0,0,4'b0000,0,8'd0,0), "idle_rst");
    run(mk(0,1,0,0,1, 1,0,0,0,0,0,4'b0000,0,8'd0,0), "idle_seed");
    run(mk(0,1,0,0,1, 1,1,1,0,0,0,4'b0000,0,8'd0,0), "idle_hold1");
    run(mk(0,1,0,0,1, 1,1,1,0,0,0,4'b0000,0,8'd0,0), "idle_hold2");
`ifdef JKDEC_IDLE_TIMEOUT_EN
    run(mk(0,1,0,0,1, 0,1,1,0,0,0,4'b0000,0,8'd0,1), "idle_hold3");
    run(mk(0,1,1,0,1, 1,0,0,0,0,0,4'b0000,0,8'd0,0), "idle_reseed");
`else
    run(mk(0,1,0,0,1, 1,1,1,0,0,0,4'b0000,0,8'd0,0), "idle_hold3");
    run(mk(0,1,1,0,1, 1,1,0,1,0,0,4'b0000,0,8'd0,0), "idle_step");
`endif

    // error counter saturates at all-ones
    run(mk(1,0,0,0,1, 0,0,0,0,0,0,4'b0000,0,8'd0,0), "sat_rst");
    run(mk(0,1,0,0,1, 1,0,0,0,0,0,4'b0000,0,8'd0,0), "sat_seed");
    for (int i = 0; i < 259; i++) begin
      if (i % 2 == 0) drive(0, 1, 1, 1, 1);
      else            drive(0, 1, 0, 0, 1);
    end
    run(mk(0,1,0,0,1, 1,0,0,0,1,0,4'b0000,0,8'hff,0), "sat_last");
    run(mk(0,0,0,0,1, 1,0,0,0,0,0,4'b0000,0,8'hff,0), "sat_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
